// File: rtl/adder_rr_arbiter.sv
// Round-robin front end that shares one Brent-Kung adder between NUM_REQ
// requesters and registers each result, tagged with the winner's index,
// in a single-entry valid/ready response slot.

`ifndef ADDER_SIZE
`define ADDER_SIZE 32
`endif

module brent_kung_adder_nbit (
   input  logic [`ADDER_SIZE-1:0] in_a,
   input  logic [`ADDER_SIZE-1:0] in_b,
   input  logic                   cin,
   output logic [`ADDER_SIZE-1:0] out_res,
   output logic                   cout
);
   localparam int unsigned N = `ADDER_SIZE;
   localparam int unsigned P = 1 << $clog2(N);

   logic [P-1:0] gen;
   logic [P-1:0] prop;
   logic [P-1:0] bit_p;

   // Prefix tree: carry-in is folded into bit 0's generate, so gen[i]
   // ends up as the carry out of bit i. Width is padded to a power of two.
   always_comb begin
      gen            = '0;
      prop           = '0;
      bit_p          = '0;
      out_res        = '0;
      bit_p[N-1:0]   = in_a ^ in_b;
      gen[N-1:0]     = in_a & in_b;
      prop[N-1:0]    = bit_p[N-1:0];
      gen[0]         = gen[0] | (prop[0] & cin);
      for (int unsigned d = 1; d < P; d = d * 2) begin
         for (int unsigned i = 2 * d - 1; i < P; i = i + 2 * d) begin
            gen[i]  = gen[i] | (prop[i] & gen[i-d]);
            prop[i] = prop[i] & prop[i-d];
         end
      end
      for (int unsigned d = P / 4; d >= 1; d = d / 2) begin
         for (int unsigned i = 3 * d - 1; i < P; i = i + 2 * d) begin
            gen[i] = gen[i] | (prop[i] & gen[i-d]);
         end
      end
      out_res[0] = bit_p[0] ^ cin;
      for (int unsigned i = 1; i < N; i++) begin
         out_res[i] = bit_p[i] ^ gen[i-1];
      end
      cout = gen[N-1];
   end
endmodule

module adder_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = `ADDER_SIZE,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       in_req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] in_req_op1,
   input  logic [NUM_REQ*WIDTH-1:0] in_req_op2,
   input  logic [NUM_REQ-1:0]       in_req_cin,
   output logic [NUM_REQ-1:0]       out_req_ready,
   output logic                     out_rsp_valid,
   output logic [ID_W-1:0]          out_rsp_id,
   output logic [WIDTH-1:0]         out_rsp_res,
   output logic                     out_rsp_cout,
   input  logic                     in_rsp_ready
);
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_t;

   slot_t            state;
   slot_t            state_next;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic             avail;
   logic             accept;
   logic             rsp_xfer;
   logic [WIDTH-1:0] op1_sel;
   logic [WIDTH-1:0] op2_sel;
   logic             cin_sel;
   logic [WIDTH-1:0] sum;
   logic             sum_cout;

   // Search for the first valid requester starting at rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && in_req_valid[(32'(rr_ptr) + i) % NUM_REQ]) begin
            found  = 1'b1;
            winner = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
         end
      end
   end

   // Grant only when the slot can take a result this cycle and not in reset.
   always_comb begin
      avail         = (state == S_EMPTY) || in_rsp_ready;
      accept        = found && avail && !rst;
      rsp_xfer      = (state == S_FULL) && in_rsp_ready;
      out_rsp_valid = (state == S_FULL);
      out_req_ready = '0;
      if (accept) begin
         out_req_ready[winner] = 1'b1;
      end
   end

   assign op1_sel = in_req_op1[winner*WIDTH +: WIDTH];
   assign op2_sel = in_req_op2[winner*WIDTH +: WIDTH];
   assign cin_sel = in_req_cin[winner];

   brent_kung_adder_nbit u_adder (
      .in_a    (op1_sel),
      .in_b    (op2_sel),
      .cin     (cin_sel),
      .out_res (sum),
      .cout    (sum_cout)
   );

   // Slot state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_EMPTY;
      else     state <= state_next;
   end

   // Slot next state: a new acceptance always refills the slot, which also
   // covers the same-cycle drain-and-fill case.
   always_comb begin
      state_next = state;
      if (accept)        state_next = S_FULL;
      else if (rsp_xfer) state_next = S_EMPTY;
   end

   // Round-robin pointer moves to one past the winner on acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   // Response payload captures the adder output on acceptance, else holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_rsp_id   <= '0;
         out_rsp_res  <= '0;
         out_rsp_cout <= 1'b0;
      end else if (accept) begin
         out_rsp_id   <= winner;
         out_rsp_res  <= sum;
         out_rsp_cout <= sum_cout;
      end
   end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.

module tb_adder_rr_arbiter;
   localparam int NR = 4;
   localparam int W  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   in_req_valid;
   logic [NR*W-1:0] in_req_op1;
   logic [NR*W-1:0] in_req_op2;
   logic [NR-1:0]   in_req_cin;
   logic [NR-1:0]   out_req_ready;
   logic            out_rsp_valid;
   logic [1:0]      out_rsp_id;
   logic [W-1:0]    out_rsp_res;
   logic            out_rsp_cout;
   logic            in_rsp_ready;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic        m_valid;
   int          m_ptr;
   int          m_id;
   logic [W:0]  m_sum;
   int          wait_cnt [NR];
   logic [NR-1:0] obs_grant;

   adder_rr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_req_valid  (in_req_valid),
      .in_req_op1    (in_req_op1),
      .in_req_op2    (in_req_op2),
      .in_req_cin    (in_req_cin),
      .out_req_ready (out_req_ready),
      .out_rsp_valid (out_rsp_valid),
      .out_rsp_id    (out_rsp_id),
      .out_rsp_res   (out_rsp_res),
      .out_rsp_cout  (out_rsp_cout),
      .in_rsp_ready  (in_rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model,
   // then return just after the rising edge so the caller can change inputs.
   task automatic cycle();
      int   w;
      int   k;
      logic avail;
      logic [NR-1:0] exp_grant;
      @(negedge clk);
      avail = !m_valid || in_rsp_ready;
      w = -1;
      if (!rst && avail) begin
         for (int i = 0; i < NR; i++) begin
            k = (m_ptr + i) % NR;
            if (w < 0 && in_req_valid[k]) w = k;
         end
      end
      exp_grant = (w >= 0) ? NR'(1 << w) : '0;
      obs_grant = out_req_ready;
      check("grant", 64'(out_req_ready), 64'(exp_grant));
      check("rsp_valid", 64'(out_rsp_valid), 64'(m_valid));
      if (m_valid) begin
         check("rsp_id", 64'(out_rsp_id), 64'(m_id));
         check("rsp_sum", 64'({out_rsp_cout, out_rsp_res}), 64'(m_sum));
      end
      for (int j = 0; j < NR; j++) begin
         if (rst || !in_req_valid[j] || out_req_ready[j]) wait_cnt[j] = 0;
         else if (avail) wait_cnt[j]++;
         if (in_req_valid[j]) check("starve", 64'(wait_cnt[j] > NR), 64'(0));
      end
      if (rst) begin
         m_valid = 1'b0;
         m_ptr   = 0;
      end else if (w >= 0) begin
         m_valid = 1'b1;
         m_id    = w;
         m_sum   = {1'b0, in_req_op1[w*W +: W]} + {1'b0, in_req_op2[w*W +: W]} + (W+1)'(in_req_cin[w]);
         m_ptr   = (w + 1) % NR;
      end else if (m_valid && in_rsp_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   initial begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_id    = 0;
      m_sum   = '0;
      for (int j = 0; j < NR; j++) wait_cnt[j] = 0;
      rst          = 1'b1;
      in_req_valid = '1;
      in_req_op1   = {$urandom, $urandom, $urandom, $urandom};
      in_req_op2   = {$urandom, $urandom, $urandom, $urandom};
      in_req_cin   = 4'b1010;
      in_rsp_ready = 1'b1;
      @(posedge clk);
      #1;

      // reset with all requesters valid
      repeat (2) cycle();
      rst = 1'b0;
      in_req_valid = '0;
      check("rst_valid", 64'(out_rsp_valid), 64'(0));
      check("rst_id", 64'(out_rsp_id), 64'(0));
      check("rst_res", 64'(out_rsp_res), 64'(0));
      check("rst_cout", 64'(out_rsp_cout), 64'(0));
      in_req_valid = '1;
      cycle();
      check("rst_ptr", 64'(obs_grant), 64'(4'b0001));

      // single add from requester 2
      in_req_valid = 4'b0100;
      in_req_op1[2*W +: W] = 32'hFFFF_FFFF;
      in_req_op2[2*W +: W] = 32'h0000_0001;
      in_req_cin[2] = 1'b0;
      cycle();
      in_req_valid = '0;
      check("single_valid", 64'(out_rsp_valid), 64'(1));
      check("single_id", 64'(out_rsp_id), 64'(2));
      check("single_res", 64'(out_rsp_res), 64'(0));
      check("single_cout", 64'(out_rsp_cout), 64'(1));
      cycle();

      // round-robin fairness
      do_reset(1);
      for (int k = 0; k < NR; k++) begin
         in_req_op1[k*W +: W] = W'(k);
         in_req_op2[k*W +: W] = 32'h10;
      end
      in_req_cin   = '1;
      in_req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("rr_grant", 64'(obs_grant), 64'(1 << (i % NR)));
         check("rr_id", 64'(out_rsp_id), 64'(i % NR));
         check("rr_res", 64'(out_rsp_res), 64'(32'h11 + (i % NR)));
      end

      // backpressure
      in_req_valid = 4'b0010;
      in_req_op1[1*W +: W] = 32'd5;
      in_req_op2[1*W +: W] = 32'd7;
      in_req_cin[1] = 1'b0;
      cycle();
      in_req_valid = 4'b1000;
      in_req_op1[3*W +: W] = 32'd100;
      in_req_op2[3*W +: W] = 32'd200;
      in_req_cin[3] = 1'b0;
      in_rsp_ready = 1'b0;
      repeat (3) begin
         cycle();
         check("bp_grant", 64'(obs_grant), 64'(0));
         check("bp_res", 64'(out_rsp_res), 64'(12));
         check("bp_id", 64'(out_rsp_id), 64'(1));
      end
      in_rsp_ready = 1'b1;
      cycle();
      check("bp_release_grant", 64'(obs_grant), 64'(4'b1000));
      check("bp_release_id", 64'(out_rsp_id), 64'(3));
      check("bp_release_res", 64'(out_rsp_res), 64'(300));

      // pointer wrap / skip
      do_reset(1);
      in_req_valid = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("wrap_grant", 64'(obs_grant), 64'((i % 2 == 0) ? 4'b0001 : 4'b1000));
      end

      // randomized compare against the model
      for (int i = 0; i < 10000; i++) begin
         rst          = ($urandom_range(0, 499) == 0);
         in_req_valid = NR'($urandom);
         in_req_op1   = {$urandom, $urandom, $urandom, $urandom};
         in_req_op2   = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 7) == 0) in_req_op1 = '1;
         in_req_cin   = NR'($urandom);
         in_rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rst          = 1'b0;
      in_req_valid = '0;
      in_rsp_ready = 1'b1;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
